// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared defaults and sample-pair type for the audio DAC path
package audio_pkg;

   localparam int SAMPLE_W_DEF     = 16;
   localparam int FRAME_CYCLES_DEF = 250;

   typedef struct packed {
      logic [SAMPLE_W_DEF-1:0] left;
      logic [SAMPLE_W_DEF-1:0] right;
   } stereo_sample_t;

endpackage

// File: rtl/audio_slot_counter.sv
// rtl/audio_slot_counter.sv - frame slot counter, LRCK flop and bit-slot strobes
module audio_slot_counter
   import audio_pkg::*;
#(
   parameter int SAMPLE_W     = SAMPLE_W_DEF,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   output logic load,
   output logic left_bit_en,
   output logic right_bit_en,
   output logic aud_daclrck
);

   localparam int CW   = $clog2(FRAME_CYCLES);
   localparam int HALF = FRAME_CYCLES / 2;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          lrck_q, lrck_d;

   // Strobes fire one cycle ahead of the slot whose data bit they launch.
   always_comb begin
      load         = (cnt_q == CW'(FRAME_CYCLES - 1));
      cnt_d        = load ? '0 : cnt_q + CW'(1);
      lrck_d       = (cnt_d < CW'(HALF));
      left_bit_en  = (cnt_q < CW'(SAMPLE_W));
      right_bit_en = (cnt_q >= CW'(HALF)) && (cnt_q < CW'(HALF + SAMPLE_W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= CW'(FRAME_CYCLES - 1);
         lrck_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lrck_q <= lrck_d;
      end
   end

   assign aud_daclrck = lrck_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - stereo PCM to I2S-style DAC frame serializer
// Optional debug taps and underrun counter under AUDIO_SERIALIZER_DEBUG_EN.
module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter int SAMPLE_W     = SAMPLE_W_DEF,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                aud_daclrck,
   output logic                aud_dacdat,
   output logic                underrun
`ifdef AUDIO_SERIALIZER_DEBUG_EN
   ,
   output logic                debug_daclrck,
   output logic                debug_dacdat,
   output logic [15:0]         underrun_cnt
`endif
);

   logic load, left_bit_en, right_bit_en, hs;

   stereo_sample_t      pend_q, pend_d;
   logic                pend_full_q, pend_full_d;
   logic                started_q, started_d;
   logic [SAMPLE_W-1:0] left_sr_q, left_sr_d;
   logic [SAMPLE_W-1:0] right_sr_q, right_sr_d;
   logic                dat_q, dat_d;
   logic                underrun_q, underrun_d;

   audio_slot_counter #(
      .SAMPLE_W     (SAMPLE_W),
      .FRAME_CYCLES (FRAME_CYCLES)
   ) u_slot_counter (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .left_bit_en  (left_bit_en),
      .right_bit_en (right_bit_en),
      .aud_daclrck  (aud_daclrck)
   );

   always_comb begin
      s_ready     = !reset && (!pend_full_q || load);
      hs          = s_valid && s_ready;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      started_d   = started_q || hs;
      left_sr_d   = left_sr_q;
      right_sr_d  = right_sr_q;
      dat_d       = 1'b0;
      underrun_d  = load && !pend_full_q && started_q;

      if (load) begin
         // An empty buffer at frame start mutes the whole frame.
         left_sr_d   = pend_full_q ? pend_q.left  : '0;
         right_sr_d  = pend_full_q ? pend_q.right : '0;
         pend_full_d = 1'b0;
      end else begin
         if (left_bit_en) begin
            dat_d     = left_sr_q[SAMPLE_W-1];
            left_sr_d = {left_sr_q[SAMPLE_W-2:0], 1'b0};
         end
         if (right_bit_en) begin
            dat_d      = right_sr_q[SAMPLE_W-1];
            right_sr_d = {right_sr_q[SAMPLE_W-2:0], 1'b0};
         end
      end

      if (hs) begin
         pend_d.left  = s_left;
         pend_d.right = s_right;
         pend_full_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         started_q   <= 1'b0;
         left_sr_q   <= '0;
         right_sr_q  <= '0;
         dat_q       <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         started_q   <= started_d;
         left_sr_q   <= left_sr_d;
         right_sr_q  <= right_sr_d;
         dat_q       <= dat_d;
         underrun_q  <= underrun_d;
      end
   end

   assign aud_dacdat = dat_q;
   assign underrun   = underrun_q;

`ifdef AUDIO_SERIALIZER_DEBUG_EN
   logic        dbg_lrck_q, dbg_dat_q;
   logic [15:0] ur_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_lrck_q <= 1'b0;
         dbg_dat_q  <= 1'b0;
         ur_cnt_q   <= '0;
      end else begin
         dbg_lrck_q <= aud_daclrck;
         dbg_dat_q  <= dat_q;
         if (underrun_q && (ur_cnt_q != 16'hFFFF)) ur_cnt_q <= ur_cnt_q + 16'd1;
      end
   end

   assign debug_daclrck = dbg_lrck_q;
   assign debug_dacdat  = dbg_dat_q;
   assign underrun_cnt  = ur_cnt_q;
`endif

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - scoreboard bench for audio_dac_serializer
module tb_audio_dac_serializer;
   import audio_pkg::*;

   localparam int W    = SAMPLE_W_DEF;
   localparam int FC   = FRAME_CYCLES_DEF;
   localparam int HALF = FC / 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [W-1:0] s_left = '0;
   logic [W-1:0] s_right = '0;
   logic         aud_daclrck, aud_dacdat, underrun;
`ifdef AUDIO_SERIALIZER_DEBUG_EN
   logic         debug_daclrck, debug_dacdat;
   logic [15:0]  underrun_cnt;
`endif

   always #5 clk = ~clk;

   audio_dac_serializer dut (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_left        (s_left),
      .s_right       (s_right),
      .aud_daclrck   (aud_daclrck),
      .aud_dacdat    (aud_dacdat),
      .underrun      (underrun)
`ifdef AUDIO_SERIALIZER_DEBUG_EN
      ,
      .debug_daclrck (debug_daclrck),
      .debug_dacdat  (debug_dacdat),
      .underrun_cnt  (underrun_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: state visible after the most recent rising edge.
   bit             m_live = 1'b0;
   int             m_cnt = FC - 1;
   bit             m_started = 1'b0;
   bit             m_underrun = 1'b0;
   logic [W-1:0]   cur_l = '0, cur_r = '0;
   stereo_sample_t sb_q[$];
   int             m_urcnt = 0;
   bit             m_dbg_l = 1'b0, m_dbg_d = 1'b0;
   int             hs_seen = 0, ur_seen = 0;

   function automatic logic exp_dat(input int slot);
      if (slot >= 1 && slot <= W) return cur_l[W-slot];
      if (slot >= HALF + 1 && slot <= HALF + W) return cur_r[HALF+W-slot];
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      logic           e_lrck, e_dat, e_rdy, ld, hs;
      stereo_sample_t nxt;
      e_lrck = (m_cnt < HALF);
      e_dat  = exp_dat(m_cnt);
      e_rdy  = !reset && (sb_q.size() == 0 || m_cnt == FC - 1);
      if (m_live) begin
         check("lrck", 32'(aud_daclrck), 32'(e_lrck));
         check("dat", 32'(aud_dacdat), 32'(e_dat));
         check("underrun", 32'(underrun), 32'(m_underrun));
         check("s_ready", 32'(s_ready), 32'(e_rdy));
`ifdef AUDIO_SERIALIZER_DEBUG_EN
         check("dbg_lrck", 32'(debug_daclrck), 32'(m_dbg_l));
         check("dbg_dat", 32'(debug_dacdat), 32'(m_dbg_d));
         check("ur_cnt", 32'(underrun_cnt), 32'(m_urcnt));
`endif
         if (s_valid && s_ready) hs_seen++;
         if (underrun) ur_seen++;
      end
      if (reset) begin
         m_live     = 1'b1;
         m_cnt      = FC - 1;
         sb_q.delete();
         m_started  = 1'b0;
         m_underrun = 1'b0;
         cur_l      = '0;
         cur_r      = '0;
         m_urcnt    = 0;
         m_dbg_l    = 1'b0;
         m_dbg_d    = 1'b0;
      end else if (m_live) begin
         m_dbg_l = e_lrck;
         m_dbg_d = e_dat;
         if (m_underrun && m_urcnt < 65535) m_urcnt++;
         hs = s_valid && e_rdy;
         ld = (m_cnt == FC - 1);
         m_underrun = 1'b0;
         if (ld) begin
            if (sb_q.size() != 0) begin
               nxt   = sb_q.pop_front();
               cur_l = nxt.left;
               cur_r = nxt.right;
            end else begin
               cur_l      = '0;
               cur_r      = '0;
               m_underrun = m_started;
            end
         end
         if (hs) begin
            nxt.left  = s_left;
            nxt.right = s_right;
            sb_q.push_back(nxt);
            m_started = 1'b1;
         end
         m_cnt = ld ? 0 : m_cnt + 1;
      end
   end

   task automatic wait_slot(input int k);
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FC; i++) begin
         @(posedge clk);
         #1;
         if (m_cnt == k) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check("wait_slot_timeout", 32'(m_cnt), 32'(k));
   endtask

   task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      bit done = 1'b0;
      s_left  = l;
      s_right = r;
      s_valid = 1'b1;
      for (int i = 0; i < 2 * FC; i++) begin
         @(negedge clk);
         #1;
         done = s_ready;
         @(posedge clk);
         #1;
         if (done) break;
      end
      s_valid = 1'b0;
      if (!done) check("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic stream(input int n);
      bit hsn;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         hsn = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (hsn) begin
            s_left  = W'($urandom);
            s_right = W'($urandom);
         end
      end
   endtask

   initial begin
      int base_hs, base_ur;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle frames after reset: muted, no underrun before any handshake.
      repeat (3 * FC) @(posedge clk);
      #1;
      check("idle_underruns", 32'(ur_seen), 32'(0));

      // Single pair with extreme bit patterns.
      wait_slot(50);
      send(16'h8001, 16'h7FFE);
      wait_slot(0);
      wait_slot(200);

      // Continuous streaming: one handshake per frame, no underrun.
      wait_slot(10);
      base_hs = hs_seen;
      base_ur = ur_seen;
      s_left  = W'($urandom);
      s_right = W'($urandom);
      s_valid = 1'b1;
      stream(10 * FC);
      check("stream_handshakes", 32'(hs_seen - base_hs), 32'(11));
      check("stream_underruns", 32'(ur_seen - base_ur), 32'(0));

      // Skip one sample: exactly one muted frame.
      wait_slot(10);
      base_ur = ur_seen;
      s_valid = 1'b0;
      wait_slot(0);
      wait_slot(10);
      wait_slot(0);
      wait_slot(10);
      check("skip_underruns", 32'(ur_seen - base_ur), 32'(1));
      s_valid = 1'b1;
      stream(2 * FC);

      // Drain, then hand over exactly on the load cycle with pend empty.
      s_valid = 1'b0;
      wait_slot(0);
      wait_slot(10);
      wait_slot(FC - 1);
      base_ur = ur_seen;
      s_left  = 16'h1234;
      s_right = 16'hABCD;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      wait_slot(10);
      check("load_hs_underrun", 32'(ur_seen - base_ur), 32'(1));
      wait_slot(0);
      wait_slot(20);

      // Reset in the middle of a left half carrying 0xFFFF, with pend full.
      send(16'hFFFF, 16'h0F0F);
      wait_slot(0);
      wait_slot(30);
      send(16'h5555, 16'hAAAA);
      wait_slot(60);
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      base_ur = ur_seen;
      repeat (3 * FC) @(posedge clk);
      #1;
      check("post_reset_underruns", 32'(ur_seen - base_ur), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
